// File: rtl/rf_writeback_scheduler.sv
// rf_writeback_scheduler: round-robin ALU/load arbitration onto the register-file write port with a pending-write scoreboard.
// Define RF_WB_FORWARD_EN to bypass the committing value to decode and drop its hazard.
module rf_writeback_scheduler #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                alu_byte,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                mem_byte,
    input  logic                sb_set,
    input  logic [ADDR_W-1:0]   sb_reg,
    input  logic [ADDR_W-1:0]   rd_reg1,
    input  logic [ADDR_W-1:0]   rd_reg2,
    output logic                hazard,
    output logic                rf_write_en,
    output logic [ADDR_W-1:0]   rf_write_reg,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic                rf_byte_op,
    output logic [NUM_REGS-1:0] pending_mask
`ifdef RF_WB_FORWARD_EN
    ,
    output logic                fwd1_hit,
    output logic                fwd2_hit,
    output logic [DATA_W-1:0]   fwd_data
`endif
);
    logic                last_mem_q, last_mem_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   wreg_q, wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wbyte_q, wbyte_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                accept, hit1, hit2;

    // last_mem_q=1 means the load side won last, so the ALU has priority next
    always_comb begin
        alu_ready  = reset_n && alu_valid && (!mem_valid || last_mem_q);
        mem_ready  = reset_n && mem_valid && (!alu_valid || !last_mem_q);
        accept     = alu_ready || mem_ready;
        last_mem_d = accept ? mem_ready : last_mem_q;
        wreg_d     = alu_ready ? alu_reg  : mem_ready ? mem_reg  : wreg_q;
        wdata_d    = alu_ready ? alu_data : mem_ready ? mem_data : wdata_q;
        wbyte_d    = alu_ready ? alu_byte : mem_ready ? mem_byte : wbyte_q;
        wen_d      = accept && (wreg_d != '0);
    end

    // a set in the same cycle as a commit to that register must win
    always_comb begin
        pend_d = pend_q;
        if (wen_q)
            pend_d[wreg_q] = 1'b0;
        if (sb_set && sb_reg != '0)
            pend_d[sb_reg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_mem_q <= 1'b1;
            wen_q      <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            wbyte_q    <= 1'b0;
            pend_q     <= '0;
        end else begin
            last_mem_q <= last_mem_d;
            wen_q      <= wen_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            wbyte_q    <= wbyte_d;
            pend_q     <= pend_d;
        end
    end

`ifdef RF_WB_FORWARD_EN
    always_comb begin
        hit1 = wen_q && !wbyte_q && wreg_q == rd_reg1 && !(sb_set && sb_reg == rd_reg1);
        hit2 = wen_q && !wbyte_q && wreg_q == rd_reg2 && !(sb_set && sb_reg == rd_reg2);
    end
    assign fwd1_hit = hit1;
    assign fwd2_hit = hit2;
    assign fwd_data = wdata_q;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign hazard        = (pend_q[rd_reg1] && !hit1) || (pend_q[rd_reg2] && !hit2);
    assign rf_write_en   = wen_q;
    assign rf_write_reg  = wreg_q;
    assign rf_write_data = wdata_q;
    assign rf_byte_op    = wbyte_q;
    assign pending_mask  = pend_q;
endmodule

// File: doc/rf_writeback_scheduler.md
Name: rf_writeback_scheduler

Overview:
Shares the single register-file write port between two write-back requesters: ALU results and memory-load results.
- Arbitrates round-robin between them and drives the register file's write_reg / write_data / regWrite / byteOperations inputs from a registered output stage.
- Keeps a per-register pending-write scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register block.

Parameters:
- NUM_REGS, 32, number of architectural registers (scoreboard depth).
- ADDR_W, 5, register index width.
- DATA_W, 32, write data width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- alu_valid  input  1  ALU write-back request
- alu_ready  output  1  ALU request accepted this cycle
- alu_reg  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_byte  input  1  ALU byte-operation flag
- mem_valid  input  1  load write-back request
- mem_ready  output  1  load request accepted this cycle
- mem_reg  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- mem_byte  input  1  load byte-operation flag
- sb_set  input  1  decode issued an instruction that will write sb_reg
- sb_reg  input  ADDR_W  register to mark pending
- rd_reg1  input  ADDR_W  decode source register 1
- rd_reg2  input  ADDR_W  decode source register 2
- hazard  output  1  rd_reg1 or rd_reg2 has a pending write
- rf_write_en  output  1  drives regWrite
- rf_write_reg  output  ADDR_W  drives write_reg
- rf_write_data  output  DATA_W  drives write_data
- rf_byte_op  output  1  drives byteOperations
- pending_mask  output  NUM_REGS  scoreboard state, bit i = register i pending

Behaviour:
Reset (reset_n low at a clock edge):
- rf_write_en=0, rf_write_reg=0, rf_write_data=0, rf_byte_op=0, pending_mask=0, last_grant=MEM.
- Consequently, ALU wins the first contested cycle.
- Reset mid-transfer discards any registered but uncommitted write.
- While reset_n is low, alu_ready and mem_ready are forced 0.

Arbitration (combinational, same cycle):
- Only one valid: that requester's ready=1.
- Both valid: grant the requester not equal to last_grant.
- Neither valid: both ready=0.
- last_grant updates to the granted requester on each accept (valid&&ready).
- Requesters must hold valid/reg/data/byte stable until ready. No request is ever dropped.

Write stage (1-cycle latency):
- An accept at edge N loads rf_write_reg/data/byte_op, and rf_write_en=1 during cycle N+1.
- rf_write_en=0 in any cycle following no accept.
- Back-to-back accepts give consecutive one-cycle write pulses; throughput is one write per cycle.
- Accept with reg==0: handshake completes but rf_write_en stays 0 (r0 never written).

Scoreboard:
- Commit: in a cycle with rf_write_en=1, pending_mask[rf_write_reg] clears at the next edge.
- Set: sb_set=1 sets pending_mask[sb_reg] at the next edge; sb_reg==0 is ignored.
- Simultaneous set and commit on the same register: set wins (bit stays 1).
- Set and commit on different registers both take effect.
- hazard (combinational) = pending_mask[rd_reg1] | pending_mask[rd_reg2].
- rd_reg==0 never raises hazard.
- Scoreboard does not count multiple outstanding writes to one register: one commit clears it. Decode must not issue a second writer to a pending register.

Optional Feature:
RF_WB_FORWARD_EN
- Defined:
  - A register currently committing (rf_write_en=1, rf_write_reg==rd_regX, bit not being re-set by sb_set) does not contribute to hazard.
  - Extra outputs fwd1_hit/fwd2_hit (1 bit) and fwd_data (DATA_W = rf_write_data) let decode bypass the value.
  - Forwarding is suppressed (hit=0, hazard kept) when rf_byte_op=1.
- Undefined: outputs absent; hazard is purely pending_mask-based and a committing register stalls one extra cycle.

Test Plan:
1. Reset, then alu_valid=1, reg=5, data=0x1234_5678 alone -> alu_ready=1 same cycle; next cycle rf_write_en=1, rf_write_reg=5, rf_write_data=0x12345678; following cycle rf_write_en=0.
2. alu_valid and mem_valid held high 4 cycles, regs 3/4 -> grants alternate ALU, MEM, ALU, MEM, starting with ALU after reset; rf_write_reg sequence 3,4,3,4 with no gaps.
3. sb_set reg 7, then rd_reg1=7 -> hazard=1 until the cycle after rf_write_en=1 with reg 7; then hazard=0 and pending_mask[7]=0.
4. Same cycle: sb_set reg 9 while committing reg 9 -> pending_mask[9] remains 1 and hazard for rd_reg2=9 stays 1.
5. mem_valid reg=0, data=0xFFFF_FFFF -> mem_ready=1, rf_write_en stays 0; sb_set reg 0 -> pending_mask stays 0.
6. Accept ALU write reg 6, assert reset_n=0 on the next edge -> rf_write_en=0, pending_mask=0, ready=0 during reset. With RF_WB_FORWARD_EN, committing reg 6 with rd_reg1=6 -> hazard=0, fwd1_hit=1, fwd_data=write value.
